// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- fetch-stage program counter with redirect, stall, misaligned-jump
// detection and a circular return-address stack (RAS).
//
// Parameters:
//   XLEN          address width in bits
//   RESET_VECTOR  PC value loaded on reset
//   STEP          sequential increment in bytes
//   RAS_DEPTH     number of RAS entries (power of two, >= 2)
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   stall             hold the PC this cycle (redirects still win)
//   jump_enable       take jump_address (if word aligned)
//   jump_address      jump/branch target
//   trap_enable       take trap_vector (highest priority, never checked)
//   trap_vector       trap handler address
//   ras_push          push push_address onto the RAS
//   push_address      return address to push
//   ras_pop           pop the top RAS entry
//   address_out       current PC
//   next_address_out  address_out + STEP (wraps)
//   ras_top           top RAS entry, 0 when empty
//   ras_valid         RAS non-empty
//   misaligned        one-cycle pulse: a jump was rejected last cycle
//   fault_address     target of the most recently rejected jump
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump_enable,
  input  logic [XLEN-1:0] jump_address,
  input  logic            trap_enable,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            ras_push,
  input  logic [XLEN-1:0] push_address,
  input  logic            ras_pop,
  output logic [XLEN-1:0] address_out,
  output logic [XLEN-1:0] next_address_out,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] fault_address
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misaligned_reg, misaligned_next;
  logic [XLEN-1:0] fault_reg, fault_next;

  assign next_address_out = pc_reg + XLEN'(STEP);

  always_comb begin
    pc_next         = pc_reg;
    misaligned_next = 1'b0;
    fault_next      = fault_reg;
    if (trap_enable) begin
      pc_next = trap_vector;
    end else if (jump_enable && (jump_address[1:0] == 2'b00)) begin
      pc_next = jump_address;
    end else begin
      // A rejected jump is reported but otherwise behaves like no jump at
      // all, so the stall still applies to it.
      if (jump_enable) begin
        misaligned_next = 1'b1;
        fault_next      = jump_address;
      end
      if (!stall) begin
        pc_next = next_address_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_VECTOR;
      misaligned_reg <= 1'b0;
      fault_reg      <= '0;
    end else begin
      pc_reg         <= pc_next;
      misaligned_reg <= misaligned_next;
      fault_reg      <= fault_next;
    end
  end

  assign address_out   = pc_reg;
  assign misaligned    = misaligned_reg;
  assign fault_address = fault_reg;

  // ---------------------------------------------------------------------------
  // Return-address stack: ptr_reg points at the next free slot, the top entry
  // lives at ptr_reg-1. When full, a push silently overwrites the oldest entry
  // because the pointer simply wraps onto it.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

  assign top_idx   = ptr_reg - PTR_W'(1);
  assign ras_empty = (count_reg == '0);

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    mem_we     = 1'b0;
    mem_waddr  = ptr_reg;
    if (ras_push && ras_pop && !ras_empty) begin
      // Return followed by a call: replace the top entry in place.
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (ras_push) begin
      mem_we   = 1'b1;
      ptr_next = ptr_reg + PTR_W'(1);
      if (count_reg != CNT_FULL) begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (ras_pop && !ras_empty) begin
      ptr_next   = top_idx;
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; an empty stack masks it on the read side.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ras_mem[mem_waddr] <= push_address;
    end
  end

  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];
  assign ras_valid = !ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h100;

  logic        clk;
  logic        reset;
  logic        stall, jump_enable, trap_enable, ras_push, ras_pop;
  logic [31:0] jump_address, trap_vector, push_address;
  logic [31:0] address_out, next_address_out, ras_top, fault_address;
  logic        ras_valid, misaligned;

  pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump_enable(jump_enable), .jump_address(jump_address),
    .trap_enable(trap_enable), .trap_vector(trap_vector),
    .ras_push(ras_push), .push_address(push_address), .ras_pop(ras_pop),
    .address_out(address_out), .next_address_out(next_address_out),
    .ras_top(ras_top), .ras_valid(ras_valid),
    .misaligned(misaligned), .fault_address(fault_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC as plain integer arithmetic, RAS as a bounded stack.
  logic [31:0] m_pc, m_fault;
  logic        m_mis;
  logic [31:0] m_ras[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_fault = 32'h0;
    m_mis   = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic jump_bad;
    jump_bad = jump_enable && (jump_address % 4 != 0);
    if (trap_enable)                  m_pc = trap_vector;
    else if (jump_enable && !jump_bad) m_pc = jump_address;
    else if (!stall)                  m_pc = m_pc + 32'd4;
    m_mis = jump_bad && !trap_enable;
    if (m_mis) m_fault = jump_address;
    if (ras_push && ras_pop && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = push_address;
    end else if (ras_push) begin
      m_ras.push_back(push_address);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (ras_pop && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_top;
    exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    check({tag, ".pc"},    address_out, m_pc);
    check({tag, ".npc"},   next_address_out, m_pc + 32'd4);
    check({tag, ".top"},   ras_top, exp_top);
    check({tag, ".valid"}, {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
    check({tag, ".mis"},   {31'b0, misaligned}, {31'b0, m_mis});
    check({tag, ".fault"}, fault_address, m_fault);
    $display("%s: pc=%h top=%h valid=%0b mis=%0b fault=%h", tag, address_out,
             ras_top, ras_valid, misaligned, fault_address);
  endtask

  task automatic set_in(input bit s, input bit je, input logic [31:0] ja,
                        input bit te, input logic [31:0] tv,
                        input bit pu, input logic [31:0] pd, input bit po);
    stall = s; jump_enable = je; jump_address = ja;
    trap_enable = te; trap_vector = tv;
    ras_push = pu; push_address = pd; ras_pop = po;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #2 check_all("reset");
    #5 reset = 1'b0;   // released between edges
    check_all("post_reset");

    // Free running from the reset vector.
    for (int i = 0; i < 3; i++) cycle("free");
    check("free_end", address_out, 32'h10C);

    // Stall, jump during stall, then trap beats jump.
    set_in(0, 1, 32'h20, 0, 0, 0, 0, 0);  cycle("jump20");
    set_in(1, 0, 0, 0, 0, 0, 0, 0);       cycle("stall1");
    set_in(1, 1, 32'h80, 0, 0, 0, 0, 0);  cycle("stall_jump");
    check("stall_jump_pc", address_out, 32'h80);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);       cycle("after_jump");
    set_in(0, 1, 32'h80, 1, 32'h400, 0, 0, 0); cycle("trap_jump");
    check("trap_wins", address_out, 32'h400);

    // Misaligned jump rejection.
    set_in(0, 1, 32'h10, 0, 0, 0, 0, 0);  cycle("jump10");
    set_in(0, 1, 32'h82, 0, 0, 0, 0, 0);  cycle("misjump");
    check("mis_pc", address_out, 32'h14);
    check("mis_pulse", {31'b0, misaligned}, 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);       cycle("mis_clear");
    check("fault_hold", fault_address, 32'h82);
    set_in(0, 1, 32'h86, 1, 32'h200, 0, 0, 0); cycle("trap_mis");
    check("trap_no_pulse", {31'b0, misaligned}, 32'h0);

    // PC wrap.
    set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); cycle("jump_top");
    check("wrap_npc", next_address_out, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);       cycle("wrap");
    check("wrap_pc", address_out, 32'h0);

    // RAS overflow and underflow.
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 32'hA + 32'(i), 0); cycle("push");
    end
    check("ras_full_top", ras_top, 32'hE);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle("pop");
    end
    check("ras_empty_top", ras_top, 32'h0);

    // Simultaneous push/pop replaces the top.
    set_in(0, 0, 0, 0, 0, 1, 32'h10, 0); cycle("push10");
    set_in(0, 0, 0, 0, 0, 1, 32'h20, 1); cycle("pushpop20");
    check("pushpop_top", ras_top, 32'h20);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);      cycle("pop_single");
    check("count_one", {31'b0, ras_valid}, 32'h0);
    set_in(0, 0, 0, 0, 0, 1, 32'h30, 1); cycle("pushpop_empty");
    set_in(0, 1, 32'h40, 0, 0, 1, 32'h34, 0); cycle("pre_reset");

    // Asynchronous reset in the middle of a cycle, with a redirect pending.
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    #2 reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("after_async");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ja;
      ja = $urandom;
      if ($urandom_range(0, 2) != 0) ja[1:0] = 2'b00;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ja,
             $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
